// File: rtl/qnr_pipe_divider.sv
// qnr_pipe_divider: fully pipelined restoring divider, one op per enabled cycle.
// Define QNR_DIV_ROUND_EN for half-away-from-zero rounding of the quotient.
module qnr_pipe_divider #(
    parameter int Z_WIDTH   = 16,
    parameter int D_WIDTH   = 8,
    parameter int SIGNED    = 1,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 in_valid,
    input  logic [Z_WIDTH-1:0]   z,
    input  logic [D_WIDTH-1:0]   d,
    input  logic [TAG_WIDTH-1:0] tag_in,
    output logic                 out_valid,
    output logic [Z_WIDTH-1:0]   q,
    output logic [D_WIDTH-1:0]   r,
    output logic [TAG_WIDTH-1:0] tag_out,
    output logic                 dz,
    output logic                 ovf
);
    localparam bit SGN = (SIGNED != 0);
    localparam int NS  = Z_WIDTH + 1;
    localparam logic [Z_WIDTH-1:0] QMAX = {1'b0, {(Z_WIDTH-1){1'b1}}};
    localparam logic [Z_WIDTH-1:0] QMIN = {1'b1, {(Z_WIDTH-1){1'b0}}};

    // Index 0 holds magnitudes; index i holds the state after iteration i.
    logic                 vld_q [NS];
    logic                 vld_d [NS];
    logic [Z_WIDTH-1:0]   zq_q  [NS];
    logic [Z_WIDTH-1:0]   zq_d  [NS];
    logic [D_WIDTH-1:0]   rem_q [NS];
    logic [D_WIDTH-1:0]   rem_d [NS];
    logic [D_WIDTH-1:0]   dm_q  [NS];
    logic [D_WIDTH-1:0]   dm_d  [NS];
    logic                 zs_q  [NS];
    logic                 zs_d  [NS];
    logic                 qn_q  [NS];
    logic                 qn_d  [NS];
    logic                 dz_q  [NS];
    logic                 dz_d  [NS];
    logic                 ov_q  [NS];
    logic                 ov_d  [NS];
    logic [TAG_WIDTH-1:0] tag_q [NS];
    logic [TAG_WIDTH-1:0] tag_d [NS];

    logic [D_WIDTH:0]     sh;
    logic                 ge;
    logic                 zneg;
    logic                 dneg;

    logic                 oval_q;
    logic [Z_WIDTH-1:0]   q_q;
    logic [Z_WIDTH-1:0]   q_d;
    logic [D_WIDTH-1:0]   r_q;
    logic [D_WIDTH-1:0]   r_d;
    logic [TAG_WIDTH-1:0] tago_q;
    logic                 dzo_q;
    logic                 ovo_q;
    logic [Z_WIDTH-1:0]   qm;
`ifdef QNR_DIV_ROUND_EN
    logic [Z_WIDTH-1:0]   lim;
`endif

    always_comb begin
        zneg     = SGN && z[Z_WIDTH-1];
        dneg     = SGN && d[D_WIDTH-1];
        vld_d[0] = in_valid;
        zq_d[0]  = zneg ? -z : z;
        rem_d[0] = '0;
        dm_d[0]  = dneg ? -d : d;
        zs_d[0]  = zneg;
        qn_d[0]  = zneg ^ dneg;
        dz_d[0]  = (d == '0);
        ov_d[0]  = SGN && (z == QMIN) && (d == '1);
        tag_d[0] = tag_in;
        sh = '0;
        ge = 1'b0;
        for (int i = 1; i < NS; i++) begin
            sh       = {rem_q[i-1], zq_q[i-1][Z_WIDTH-1]};
            ge       = (sh >= {1'b0, dm_q[i-1]});
            rem_d[i] = ge ? D_WIDTH'(sh - {1'b0, dm_q[i-1]})
                          : sh[D_WIDTH-1:0];
            zq_d[i]  = {zq_q[i-1][Z_WIDTH-2:0], ge};
            vld_d[i] = vld_q[i-1];
            dm_d[i]  = dm_q[i-1];
            zs_d[i]  = zs_q[i-1];
            qn_d[i]  = qn_q[i-1];
            dz_d[i]  = dz_q[i-1];
            ov_d[i]  = ov_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
    end

    always_comb begin
        qm = zq_q[Z_WIDTH];
`ifdef QNR_DIV_ROUND_EN
        lim = !SGN ? {Z_WIDTH{1'b1}} : (qn_q[Z_WIDTH] ? QMIN : QMAX);
        if (({rem_q[Z_WIDTH], 1'b0} >= {1'b0, dm_q[Z_WIDTH]}) && (qm < lim))
            qm = qm + Z_WIDTH'(1);
`endif
        q_d = (SGN && qn_q[Z_WIDTH]) ? -qm : qm;
        r_d = (SGN && zs_q[Z_WIDTH]) ? -rem_q[Z_WIDTH] : rem_q[Z_WIDTH];
        if (dz_q[Z_WIDTH]) begin
            q_d = !SGN ? {Z_WIDTH{1'b1}} : (zs_q[Z_WIDTH] ? QMIN : QMAX);
            r_d = '0;
        end else if (ov_q[Z_WIDTH]) begin
            q_d = QMAX;
            r_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NS; i++) begin
                vld_q[i] <= 1'b0;
                zq_q[i]  <= '0;
                rem_q[i] <= '0;
                dm_q[i]  <= '0;
                zs_q[i]  <= 1'b0;
                qn_q[i]  <= 1'b0;
                dz_q[i]  <= 1'b0;
                ov_q[i]  <= 1'b0;
                tag_q[i] <= '0;
            end
            oval_q <= 1'b0;
            q_q    <= '0;
            r_q    <= '0;
            tago_q <= '0;
            dzo_q  <= 1'b0;
            ovo_q  <= 1'b0;
        end else if (ena) begin
            for (int i = 0; i < NS; i++) begin
                vld_q[i] <= vld_d[i];
                zq_q[i]  <= zq_d[i];
                rem_q[i] <= rem_d[i];
                dm_q[i]  <= dm_d[i];
                zs_q[i]  <= zs_d[i];
                qn_q[i]  <= qn_d[i];
                dz_q[i]  <= dz_d[i];
                ov_q[i]  <= ov_d[i];
                tag_q[i] <= tag_d[i];
            end
            oval_q <= vld_q[Z_WIDTH];
            q_q    <= q_d;
            r_q    <= r_d;
            tago_q <= tag_q[Z_WIDTH];
            dzo_q  <= dz_q[Z_WIDTH];
            ovo_q  <= ov_q[Z_WIDTH] && !dz_q[Z_WIDTH];
        end
    end

    assign out_valid = oval_q;
    assign q         = q_q;
    assign r         = r_q;
    assign tag_out   = tago_q;
    assign dz        = dzo_q;
    assign ovf       = ovo_q;

endmodule

// File: tb/tb_qnr_pipe_divider.sv
// tb_qnr_pipe_divider: directed and stalled-random checks of the divider,
// plus an unsigned 12/12 instance.
module tb_qnr_pipe_divider;

`ifdef QNR_DIV_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic [3:0]  tag;
        logic        dz;
        logic        ov;
        int          iss;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        in_valid;
    logic [15:0] z;
    logic [7:0]  d;
    logic [3:0]  tag_in;
    logic        out_valid;
    logic [15:0] q;
    logic [7:0]  r;
    logic [3:0]  tag_out;
    logic        dz;
    logic        ovf;

    logic        ena2;
    logic        iv2;
    logic [11:0] z2;
    logic [11:0] d2;
    logic [3:0]  ti2;
    logic        ovld2;
    logic [11:0] q2;
    logic [11:0] r2;
    logic [3:0]  to2;
    logic        dz2;
    logic        ovf2;

    int   n_chk;
    int   n_pass;
    int   ecyc;
    exp_t exq[$];
    exp_t none;
    logic pv;
    logic [15:0] pq;
    int   zi;
    int   di;
    int   issued;
    int   guard;
    logic en;

    int tz[14] = '{100, -100, 100, -100, 5, -5, -32768, 11, -11,
                   32767, -32768, -32768, 32767, 0};
    int td[14] = '{7, 7, -7, -7, 0, 0, -1, 2, 2, 1, 1, -128, -128, -3};
    int tq[14] = '{14, -14, -14, 14, 32767, -32768, 32767, 5 + RND,
                   -5 - RND, 32767, -32768, 256, -255 - RND, 0};
    int tr[14] = '{2, -2, 2, -2, 0, 0, 0, 1, -1, 0, 0, 0, 127, 0};
    int tdz[14] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    int tov[14] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};

    qnr_pipe_divider u_dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .in_valid (in_valid),
        .z        (z),
        .d        (d),
        .tag_in   (tag_in),
        .out_valid(out_valid),
        .q        (q),
        .r        (r),
        .tag_out  (tag_out),
        .dz       (dz),
        .ovf      (ovf)
    );

    qnr_pipe_divider #(
        .Z_WIDTH  (12),
        .D_WIDTH  (12),
        .SIGNED   (0),
        .TAG_WIDTH(4)
    ) u_dut_u (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena2),
        .in_valid (iv2),
        .z        (z2),
        .d        (d2),
        .tag_in   (ti2),
        .out_valid(ovld2),
        .q        (q2),
        .r        (r2),
        .tag_out  (to2),
        .dz       (dz2),
        .ovf      (ovf2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, got, exp);
    endtask

    function automatic exp_t mk(input int qv, input int rv, input int tg,
                                input int fdz, input int fov);
        exp_t e;
        e.q   = 16'(qv);
        e.r   = 8'(rv);
        e.tag = 4'(tg);
        e.dz  = (fdz != 0);
        e.ov  = (fov != 0);
        e.iss = 0;
        return e;
    endfunction

    // Reference built on the simulator's truncating integer division.
    function automatic exp_t model(input int zz, input int dd, input int tg);
        int qi;
        int ri;
`ifdef QNR_DIV_ROUND_EN
        int qa;
        int ra;
        int da;
        bit ng;
`endif
        if (dd == 0) return mk(zz < 0 ? -32768 : 32767, 0, tg, 1, 0);
        if (zz == -32768 && dd == -1) return mk(32767, 0, tg, 0, 1);
        qi = zz / dd;
        ri = zz % dd;
`ifdef QNR_DIV_ROUND_EN
        ng = (zz < 0) != (dd < 0);
        qa = qi < 0 ? -qi : qi;
        ra = ri < 0 ? -ri : ri;
        da = dd < 0 ? -dd : dd;
        if (2 * ra >= da && qa < (ng ? 32768 : 32767)) qa++;
        qi = ng ? -qa : qa;
`endif
        return mk(qi, ri, tg, 0, 0);
    endfunction

    task automatic step(input logic e_n, input logic vld,
                        input logic [15:0] zz, input logic [7:0] dd,
                        input logic [3:0] tg, input exp_t ex);
        exp_t x;
        ena      = e_n;
        in_valid = vld;
        z        = zz;
        d        = dd;
        tag_in   = tg;
        @(posedge clk);
        #1;
        if (e_n) begin
            ecyc++;
            if (exq.size() == 0) begin
                chk("idle", out_valid, 0);
            end else if (out_valid) begin
                x = exq.pop_front();
                chk("q", q, x.q);
                chk("r", r, x.r);
                chk("tag", tag_out, x.tag);
                chk("dz", dz, x.dz);
                chk("ovf", ovf, x.ov);
                chk("lat", ecyc - x.iss + 1, 18);
            end
            if (vld) begin
                x     = ex;
                x.iss = ecyc;
                exq.push_back(x);
            end
        end else begin
            chk("hold_v", out_valid, pv);
            chk("hold_q", q, pq);
        end
        pv = out_valid;
        pq = q;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exq.size() != 0 && n < 100) begin
            step(1'b1, 1'b0, 16'd0, 8'd0, 4'd0, none);
            n++;
        end
        chk("drain", exq.size(), 0);
        exq.delete();
        repeat (3) step(1'b1, 1'b0, 16'd0, 8'd0, 4'd0, none);
    endtask

    task automatic rst_pulse();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_vld", out_valid, 0);
        exq.delete();
        @(posedge clk);
        #1;
        chk("rst_vld2", out_valid, 0);
        rst = 1'b1;
        pv  = out_valid;
        pq  = q;
    endtask

    task automatic u_run(input logic [11:0] zz, input logic [11:0] dd,
                         input logic [11:0] eq, input logic [11:0] er,
                         input logic edz, input logic [3:0] tg);
        int n;
        z2  = zz;
        d2  = dd;
        ti2 = tg;
        iv2 = 1'b1;
        @(posedge clk);
        #1;
        iv2 = 1'b0;
        n   = 1;
        while (!ovld2 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("u_lat", n, 14);
        chk("u_q", q2, eq);
        chk("u_r", r2, er);
        chk("u_tag", to2, tg);
        chk("u_dz", dz2, edz);
        chk("u_ovf", ovf2, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        ecyc     = 0;
        rst      = 1'b0;
        ena      = 1'b1;
        in_valid = 1'b0;
        z        = '0;
        d        = '0;
        tag_in   = '0;
        ena2     = 1'b1;
        iv2      = 1'b0;
        z2       = '0;
        d2       = '0;
        ti2      = '0;
        none     = mk(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ov", out_valid, 0);
        chk("rst_q", q, 0);
        chk("rst_r", r, 0);
        chk("rst_tag", tag_out, 0);
        chk("rst_dz", dz, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b1;
        pv  = out_valid;
        pq  = q;

        step(1'b1, 1'b1, 16'd100, 8'd7, 4'd3, mk(14, 2, 3, 0, 0));
        drain();

        for (int i = 0; i < 14; i++) begin
            step(1'b1, 1'b1, 16'(tz[i]), 8'(td[i]), 4'(i),
                 mk(tq[i], tr[i], i, tdz[i], tov[i]));
        end
        drain();

        issued = 0;
        guard  = 0;
        while (issued < 40 && guard < 1000) begin
            en = ($urandom_range(0, 9) >= 3);
            zi = int'($signed(16'($urandom)));
            di = ($urandom_range(0, 7) == 0) ? 0
                                             : int'($signed(8'($urandom)));
            step(en, 1'b1, 16'(zi), 8'(di), 4'(issued),
                 model(zi, di, issued % 16));
            if (en) issued++;
            guard++;
        end
        chk("issued", issued, 40);
        drain();

        for (int i = 0; i < 10; i++) begin
            if (i == 5) rst_pulse();
            zi = 1000 + i * 37;
            di = 3 + i;
            step(1'b1, 1'b1, 16'(zi), 8'(di), 4'(i), model(zi, di, i));
        end
        drain();

        ena = 1'b0;
        u_run(12'd4095, 12'd4095, 12'd1, 12'd0, 1'b0, 4'd5);
        u_run(12'd4095, 12'd0, 12'd4095, 12'd0, 1'b1, 4'd6);
        u_run(12'd100, 12'd7, 12'd14, 12'd2, 1'b0, 4'd7);
        u_run(12'd4095, 12'd16, 12'(255 + RND), 12'd15, 1'b0, 4'd8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
